// File: rtl/timer_prog_seq.sv
// Programming sequencer for the 32-bit timer: turns one reload/compare/config
// request into byte load strobes and config writes, services interrupt
// acknowledges, and counts interrupt rising edges.
module timer_prog_seq #(
    parameter int         CNT_W    = 8,
    parameter logic [7:0] HALT_CNF = 8'h00
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_wr_il,
    input  logic             req_wr_cv,
    input  logic [31:0]      req_il,
    input  logic [31:0]      req_cv,
    input  logic [7:0]       req_cnf,
    output logic             done,
    output logic             busy,
    input  logic             irq_ack,
    output logic [3:0]       il_load,
    output logic [3:0]       cv_load,
    output logic             il_init,
    output logic             cv_init,
    output logic [7:0]       pload,
    output logic             load_mem,
    output logic             init_cnf,
    output logic [7:0]       cnf_in,
    input  logic [7:0]       cnf_out,
    input  logic             interrupt,
    output logic [CNT_W-1:0] irq_cnt
);

    typedef enum logic [3:0] {
        S_IDLE, S_HALT, S_IL0, S_IL1, S_IL2, S_IL3,
        S_CV0, S_CV1, S_CV2, S_CV3, S_INIT, S_START, S_DONE, S_ACK
    } state_t;

    state_t      state, state_nxt;
    logic        ack_pending;
    logic        wr_il_q, wr_cv_q;
    logic [31:0] il_q, cv_q;
    logic [7:0]  cnf_q;
    logic        irq_d;
    logic        accept;
    logic [1:0]  k;

    logic [3:0]  il_load_d, cv_load_d;
    logic        il_init_d, cv_init_d, load_mem_d, done_d;
    logic [7:0]  pload_d, cnf_in_d;

    assign req_ready = (state == S_IDLE) && !ack_pending && !irq_ack;
    assign accept    = req_valid && req_ready;
    assign busy      = (state != S_IDLE);
    assign init_cnf  = 1'b0;

    // Next-state selection
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (accept) state_nxt = S_HALT;
                     else if (irq_ack || ack_pending) state_nxt = S_ACK;
            S_HALT:  state_nxt = wr_il_q ? S_IL0 : (wr_cv_q ? S_CV0 : S_INIT);
            S_IL0:   state_nxt = S_IL1;
            S_IL1:   state_nxt = S_IL2;
            S_IL2:   state_nxt = S_IL3;
            S_IL3:   state_nxt = wr_cv_q ? S_CV0 : S_INIT;
            S_CV0:   state_nxt = S_CV1;
            S_CV1:   state_nxt = S_CV2;
            S_CV2:   state_nxt = S_CV3;
            S_CV3:   state_nxt = S_INIT;
            S_INIT:  state_nxt = S_START;
            S_START: state_nxt = S_DONE;
            S_DONE:  state_nxt = ack_pending ? S_ACK : S_IDLE;
            S_ACK:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Outputs decoded from the next state so they can be registered and line
    // up with the state they belong to; HALT uses the live request fields
    // because the capture registers load on the same edge.
    always_comb begin
        il_load_d  = '0;
        cv_load_d  = '0;
        il_init_d  = 1'b0;
        cv_init_d  = 1'b0;
        load_mem_d = 1'b0;
        done_d     = 1'b0;
        pload_d    = '0;
        cnf_in_d   = '0;
        k          = '0;
        case (state_nxt)
            S_HALT: begin
                load_mem_d = 1'b1;
                cnf_in_d   = HALT_CNF;
                il_init_d  = accept ? req_wr_il : wr_il_q;
                cv_init_d  = accept ? req_wr_cv : wr_cv_q;
            end
            S_IL0, S_IL1, S_IL2, S_IL3: begin
                k         = 2'(state_nxt - S_IL0);
                il_load_d = 4'b0001 << k;
                pload_d   = il_q[8*k +: 8];
            end
            S_CV0, S_CV1, S_CV2, S_CV3: begin
                k         = 2'(state_nxt - S_CV0);
                cv_load_d = 4'b0001 << k;
                pload_d   = cv_q[8*k +: 8];
            end
            S_INIT: begin
                load_mem_d = 1'b1;
                cnf_in_d   = 8'h02;
            end
            S_START: begin
                load_mem_d = 1'b1;
                cnf_in_d   = cnf_q & 8'hF5;
            end
            S_DONE: done_d = 1'b1;
            S_ACK: begin
                load_mem_d = 1'b1;
                cnf_in_d   = cnf_out & 8'hF7;
            end
            default: ;
        endcase
    end

    // State, request capture and collapsed acknowledge tracking
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= S_IDLE;
            ack_pending <= 1'b0;
            wr_il_q     <= 1'b0;
            wr_cv_q     <= 1'b0;
            il_q        <= '0;
            cv_q        <= '0;
            cnf_q       <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                wr_il_q <= req_wr_il;
                wr_cv_q <= req_wr_cv;
                il_q    <= req_il;
                cv_q    <= req_cv;
                cnf_q   <= req_cnf;
            end
            if (irq_ack && state != S_IDLE) ack_pending <= 1'b1;
            else if (state == S_ACK)        ack_pending <= 1'b0;
        end
    end

    // Registered strobe and data outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            il_load  <= '0;
            cv_load  <= '0;
            il_init  <= 1'b0;
            cv_init  <= 1'b0;
            load_mem <= 1'b0;
            done     <= 1'b0;
            pload    <= '0;
            cnf_in   <= '0;
        end else begin
            il_load  <= il_load_d;
            cv_load  <= cv_load_d;
            il_init  <= il_init_d;
            cv_init  <= cv_init_d;
            load_mem <= load_mem_d;
            done     <= done_d;
            pload    <= pload_d;
            cnf_in   <= cnf_in_d;
        end
    end

    // Saturating count of interrupt rising edges
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            irq_d   <= 1'b0;
            irq_cnt <= '0;
        end else begin
            irq_d <= interrupt;
            if (interrupt && !irq_d && irq_cnt != {CNT_W{1'b1}})
                irq_cnt <= irq_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_timer_prog_seq.sv
// Scoreboard bench for timer_prog_seq: the driver pushes the expected output
// beats (with their cycle numbers) when it issues stimulus; the monitor pops
// and compares whenever the DUT drives any strobe.
module tb_timer_prog_seq;

    localparam int CNT_W = 2;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             req_valid = 1'b0, req_ready;
    logic             req_wr_il = 1'b0, req_wr_cv = 1'b0;
    logic [31:0]      req_il = '0, req_cv = '0;
    logic [7:0]       req_cnf = '0;
    logic             done, busy;
    logic             irq_ack = 1'b0;
    logic [3:0]       il_load, cv_load;
    logic             il_init, cv_init, load_mem, init_cnf;
    logic [7:0]       pload, cnf_in;
    logic [7:0]       cnf_out = '0;
    logic             interrupt = 1'b0;
    logic [CNT_W-1:0] irq_cnt;

    timer_prog_seq #(.CNT_W(CNT_W), .HALT_CNF(8'h00)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_wr_il(req_wr_il), .req_wr_cv(req_wr_cv), .req_il(req_il),
        .req_cv(req_cv), .req_cnf(req_cnf), .done(done), .busy(busy),
        .irq_ack(irq_ack), .il_load(il_load), .cv_load(cv_load),
        .il_init(il_init), .cv_init(cv_init), .pload(pload),
        .load_mem(load_mem), .init_cnf(init_cnf), .cnf_in(cnf_in),
        .cnf_out(cnf_out), .interrupt(interrupt), .irq_cnt(irq_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        logic [28:0] outs;
    } beat_t;

    beat_t q[$];
    int    cyc = 0;
    int    n_checks = 0, n_pass = 0;
    int    m_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic logic [28:0] mk(input logic [3:0] ill, input logic [3:0] cvl,
                                       input logic ili, input logic cvi, input logic [7:0] pl,
                                       input logic lm, input logic [7:0] ci, input logic dn);
        return {ill, cvl, ili, cvi, pl, lm, 1'b0, ci, dn};
    endfunction

    function automatic logic [28:0] dut_outs();
        return {il_load, cv_load, il_init, cv_init, pload, load_mem, init_cnf, cnf_in, done};
    endfunction

    function automatic int nbeats(input bit wil, input bit wcv);
        return 4 + (wil ? 4 : 0) + (wcv ? 4 : 0);
    endfunction

    task automatic push(input int c, input logic [28:0] o);
        beat_t b;
        b.cyc = c; b.outs = o;
        q.push_back(b);
    endtask

    // Reference sequence for one request, starting at the accept edge a
    task automatic push_req(input bit wil, input bit wcv, input logic [31:0] il,
                            input logic [31:0] cv, input logic [7:0] cnf, input int a);
        int c;
        logic [31:0] v;
        c = a;
        push(c++, mk(4'h0, 4'h0, wil, wcv, 8'h00, 1'b1, 8'h00, 1'b0));
        if (wil) for (int i = 0; i < 4; i++) begin
            v = il >> (8 * i);
            push(c++, mk(4'(1 << i), 4'h0, 1'b0, 1'b0, v[7:0], 1'b0, 8'h00, 1'b0));
        end
        if (wcv) for (int i = 0; i < 4; i++) begin
            v = cv >> (8 * i);
            push(c++, mk(4'h0, 4'(1 << i), 1'b0, 1'b0, v[7:0], 1'b0, 8'h00, 1'b0));
        end
        push(c++, mk(4'h0, 4'h0, 1'b0, 1'b0, 8'h00, 1'b1, 8'h02, 1'b0));
        push(c++, mk(4'h0, 4'h0, 1'b0, 1'b0, 8'h00, 1'b1, cnf & 8'hF5, 1'b0));
        push(c, mk(4'h0, 4'h0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1));
    endtask

    function automatic logic [28:0] ack_beat(input logic [7:0] co);
        return mk(4'h0, 4'h0, 1'b0, 1'b0, 8'h00, 1'b1, co & 8'hF7, 1'b0);
    endfunction

    // Called right after a negedge with the DUT idle; acks are pulsed while
    // beat ack1/ack2 (1-based, 0 = none) is on the outputs.
    task automatic run_req(input bit wil, input bit wcv, input logic [31:0] il,
                           input logic [31:0] cv, input logic [7:0] cnf, input logic [7:0] co,
                           input int ack1, input int ack2);
        int a, n;
        cnf_out = co;
        req_valid = 1'b1; req_wr_il = wil; req_wr_cv = wcv;
        req_il = il; req_cv = cv; req_cnf = cnf;
        #1 chk("ready_when_idle", req_ready, 1);
        a = cyc + 1;
        n = nbeats(wil, wcv);
        push_req(wil, wcv, il, cv, cnf, a);
        if (ack1 > 0 || ack2 > 0) push(a + n, ack_beat(co));
        for (int j = 1; j <= n; j++) begin
            @(negedge clk);
            req_valid = 1'b0;
            req_wr_il = 1'($urandom); req_wr_cv = 1'($urandom);
            req_il = $urandom; req_cv = $urandom; req_cnf = 8'($urandom);
            chk("busy_during_req", {busy, req_ready}, 2'b10);
            irq_ack = (j < n) && (j == ack1 || j == ack2);
        end
        @(negedge clk);
        irq_ack = 1'b0;
        if (ack1 > 0 || ack2 > 0) @(negedge clk);
        #1 chk("ready_after_req", req_ready, 1);
    endtask

    // Monitor: every cycle with any output asserted consumes one expected beat
    always @(negedge clk) begin
        if (rst) begin
            if (dut_outs() != '0) begin
                if (q.size() == 0) chk("unexpected_output", {35'd0, dut_outs()}, 64'd0);
                else begin
                    beat_t b;
                    b = q.pop_front();
                    chk("beat_outputs", {35'd0, dut_outs()}, {35'd0, b.outs});
                    chk("beat_cycle", 64'(cyc), 64'(b.cyc));
                end
            end else if (q.size() != 0 && q[0].cyc <= cyc) begin
                chk("missing_beat", {35'd0, dut_outs()}, {35'd0, q[0].outs});
                void'(q.pop_front());
            end
        end
    end

    initial begin
        repeat (60000) @(posedge clk);
        $display("FAIL watchdog: simulation did not finish, %0d beats outstanding", q.size());
        $fatal(1);
    end

    initial begin
        bit wil, wcv;
        int n, c;
        logic [7:0] co;

        #12 rst = 1'b1;
        @(negedge clk);
        chk("reset_outputs", {35'd0, dut_outs()}, 64'd0);
        chk("reset_ready_busy", {req_ready, busy}, 2'b10);
        chk("reset_irq_cnt", irq_cnt, 0);

        // Full request
        @(negedge clk);
        run_req(1, 1, 32'h0403_0201, 32'h0000_0010, 8'h07, 8'h00, 0, 0);
        // Neither register written
        @(negedge clk);
        run_req(0, 0, 32'h0, 32'h0, 8'h0F, 8'h00, 0, 0);
        // Ack during IL1 (beat 3), serviced after DONE
        @(negedge clk);
        run_req(1, 1, 32'hDEAD_BEEF, 32'h1234_5678, 8'h05, 8'h0D, 3, 0);

        // Request and ack collide in IDLE: ack first, request next
        @(negedge clk);
        cnf_out = 8'h0C;
        req_valid = 1'b1; req_wr_il = 1; req_wr_cv = 1;
        req_il = 32'hA1B2_C3D4; req_cv = 32'h0F0E_0D0C; req_cnf = 8'hFF;
        irq_ack = 1'b1;
        #1 chk("ready_collision", req_ready, 0);
        c = cyc + 1;
        push(c, ack_beat(8'h0C));
        @(negedge clk);
        irq_ack = 1'b0;
        #1 chk("ready_in_ack", req_ready, 0);
        @(negedge clk);
        run_req(1, 1, 32'hA1B2_C3D4, 32'h0F0E_0D0C, 8'hFF, 8'h0C, 0, 0);

        // Interrupt counter saturation: expect 1,2,3,3,3
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            interrupt = 1'b1;
            m_cnt = (m_cnt < 3) ? m_cnt + 1 : 3;
            @(negedge clk);
            interrupt = 1'b0;
            chk("irq_cnt_pulse", irq_cnt, m_cnt);
        end

        // Reset while in CV2 (beat 8 of a full request)
        @(negedge clk);
        req_valid = 1'b1; req_wr_il = 1; req_wr_cv = 1;
        req_il = 32'h1111_2222; req_cv = 32'h3333_4444; req_cnf = 8'h07;
        push_req(1, 1, 32'h1111_2222, 32'h3333_4444, 8'h07, cyc + 1);
        for (int j = 1; j <= 8; j++) begin
            @(negedge clk);
            req_valid = 1'b0;
        end
        #2 rst = 1'b0;
        #1;
        chk("midreset_outputs", {35'd0, dut_outs()}, 64'd0);
        chk("midreset_busy", busy, 0);
        chk("midreset_irq_cnt", irq_cnt, 0);
        q.delete();
        m_cnt = 0;
        @(negedge clk);
        #2 rst = 1'b1;
        @(negedge clk);
        chk("post_reset_ready", {req_ready, busy}, 2'b10);
        chk("post_reset_irq_cnt", irq_cnt, 0);
        repeat (15) @(negedge clk);

        // A level held high for 10 cycles counts once
        interrupt = 1'b1;
        m_cnt = m_cnt + 1;
        repeat (10) @(negedge clk);
        interrupt = 1'b0;
        chk("irq_cnt_level", irq_cnt, m_cnt);

        // Randomized requests with acks while busy and while idle
        for (int t = 0; t < 40; t++) begin
            wil = 1'($urandom); wcv = 1'($urandom);
            n = nbeats(wil, wcv);
            co = 8'($urandom);
            @(negedge clk);
            run_req(wil, wcv, $urandom, $urandom, 8'($urandom), co,
                    ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(1, n - 1),
                    ($urandom_range(0, 3) == 0) ? $urandom_range(1, n - 1) : 0);
            if ($urandom_range(0, 3) == 0) begin
                @(negedge clk);
                co = 8'($urandom);
                cnf_out = co;
                irq_ack = 1'b1;
                push(cyc + 1, ack_beat(co));
                @(negedge clk);
                irq_ack = 1'b0;
                @(negedge clk);
            end
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        repeat (5) @(negedge clk);
        chk("scoreboard_drained", q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/timer_prog_seq.md
Name: timer_prog_seq

Overview:
- Programming sequencer for the 32-bit timer block (initial-load register, compare-value register, counter, config register).
- Accepts one 32-bit reload/compare/config request over a valid/ready handshake.
- Serializes each request into the byte-wide load strobes and config writes the timer needs, in a fixed order.
- Also services interrupt acknowledges by clearing the timer's flag bit, and counts interrupt events for software.

Parameters:
- CNT_W, 8, width of the saturating interrupt-event counter.
- HALT_CNF, 8'h00, config byte written during the HALT step.

Ports:
- clk  in  1  system clock; all state on rising edge.
- rst  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  sequencer can accept a request this cycle.
- req_wr_il  in  1  request reloads the initial-load register.
- req_wr_cv  in  1  request reloads the compare-value register.
- req_il  in  32  initial-load value.
- req_cv  in  32  compare value.
- req_cnf  in  8  final config byte (bit0 start, bit1 init, bit2 int-enable, bit3 flag).
- done  out  1  one-cycle pulse when a request completes.
- busy  out  1  state != IDLE.
- irq_ack  in  1  one-cycle acknowledge pulse from the interrupt controller.
- il_load  out  4  one-hot byte strobes to the initial-load register; bit k loads byte k.
- cv_load  out  4  one-hot byte strobes to the compare-value register.
- il_init  out  1  clear pulse to the initial-load register.
- cv_init  out  1  clear pulse to the compare-value register.
- pload  out  8  byte data for il_load/cv_load.
- load_mem  out  1  config-register write strobe.
- init_cnf  out  1  config-register clear; driven 0 in this revision.
- cnf_in  out  8  config write data.
- cnf_out  in  8  current timer config.
- interrupt  in  1  timer interrupt level.
- irq_cnt  out  CNT_W  saturating count of interrupt rising edges.

Behaviour:
- Reset (rst=0, async):
  - state=IDLE; ack_pending=0; irq_cnt=0.
  - All strobes and done are 0; pload=0; cnf_in=0.
- All strobe outputs are registered, one-cycle-wide pulses.
- Data (pload/cnf_in) is valid in the same cycle as its strobe.
- Handshake:
  - req_ready = (state==IDLE) && !ack_pending && !irq_ack.
  - A request is accepted when req_valid && req_ready; all req_* fields are captured at that edge.
  - req_* fields are don't-care at all other times.
- FSM states: IDLE, HALT, IL0..IL3, CV0..CV3, INIT, START, DONE, ACK.
  - IDLE:
    - Accept → HALT.
    - Else if irq_ack or ack_pending → ACK.
  - HALT (1 cycle):
    - load_mem=1, cnf_in=HALT_CNF. This stops the counter and clears int-enable and flag.
    - il_init=req_wr_il, cv_init=req_wr_cv.
    - Next: IL0 if wr_il, else CV0 if wr_cv, else INIT.
  - ILk (4 cycles total):
    - il_load[k]=1, pload=il[8k+7:8k].
    - IL3 → CV0 if wr_cv, else INIT.
  - CVk: same pattern as ILk, using cv_load and cv. CV3 → INIT.
  - INIT (1 cycle): load_mem=1, cnf_in=8'h02; the counter reloads from the initial-load register.
  - START (1 cycle): load_mem=1, cnf_in=cnf & 8'hF5 (init and flag forced 0).
  - DONE (1 cycle): done=1.
    - Next: ACK if ack_pending, else IDLE.
    - req_ready stays low in DONE.
  - ACK (1 cycle): load_mem=1, cnf_in=cnf_out & 8'hF7 (clears flag only); ack_pending cleared → IDLE.
- Cycle counts from the accept edge:
  - Full request (il+cv): strobes on cycles 1..11, done on cycle 12.
  - Neither il nor cv: done on cycle 4.
- irq_ack received while state!=IDLE sets ack_pending; it is serviced after DONE, before the next request.
  - Multiple acks while busy collapse into one.
- irq_ack and req_valid in the same IDLE cycle: ack wins. The request waits with req_ready=0 and is accepted in the cycle after ACK.
- irq_cnt:
  - interrupt is registered into a 1-cycle delay.
  - Increments on 0→1 transitions and saturates at all-ones.
  - Counts in every state; never cleared except by reset.
- Mid-operation reset: outputs drop to 0 asynchronously. The partial request is lost; no done pulse.
- Outputs are never asserted simultaneously except il_init with cv_init, and load_mem with il_init/cv_init in HALT.

Test Plan:
- Full request: wr_il=1, wr_cv=1, il=32'h0403_0201, cv=32'h0000_0010, cnf=8'h07 →
  - HALT with il_init=cv_init=1;
  - pload 01,02,03,04 on il_load 0001,0010,0100,1000;
  - then 10,00,00,00 on cv_load;
  - cnf_in 02 then 05;
  - done on cycle 12; req_ready low cycles 1..12.
- wr_il=wr_cv=0, cnf=8'h0F → cnf_in sequence 00, 02, 05; done on cycle 4; no il_load/cv_load pulses.
- irq_ack pulsed during IL1 with cnf_out=8'h0D → after DONE, one ACK cycle with load_mem=1 and cnf_in=8'h05; then IDLE.
- req_valid and irq_ack in the same IDLE cycle with cnf_out=8'h0C → ACK first (cnf_in=8'h04), request accepted next cycle; done 13 cycles after the collision cycle for a full request.
- Counter saturation with CNT_W=2: five interrupt pulses → irq_cnt 1, 2, 3, 3, 3; a level held high 10 cycles counts once.
- Reset asserted in CV2 → all outputs 0 immediately, state IDLE; after release req_ready=1, irq_cnt=0, no done.
